// File: rtl/clock_pkg.sv
// Field layout, BCD limits and load validation shared by the time-of-day
// counter and the date stage that watches its hour bus.
package clock_pkg;

  localparam int HH_W   = 6;
  localparam int MM_W   = 7;
  localparam int SS_W   = 7;
  localparam int TIME_W = HH_W + MM_W + SS_W;

  localparam int SS_LSB = 0;
  localparam int MM_LSB = SS_LSB + SS_W;
  localparam int HH_LSB = MM_LSB + MM_W;

  localparam logic [SS_W-1:0] SEC_MAX = 7'h59;
  localparam logic [MM_W-1:0] MIN_MAX = 7'h59;
  localparam logic [HH_W-1:0] HR_MAX  = 6'h23;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
    logic [SS_W-1:0] ss;
  } hms_t;

  // A time is loadable only if every digit is decimal and the value is a
  // real time of day; this keeps illegal BCD states out of the counters.
  function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t);
    hms_t f;
    logic ok;
    f  = hms_t'(t);
    ok = (f.ss[6:4] <= 3'd5) && (f.ss[3:0] <= 4'd9) &&
         (f.mm[6:4] <= 3'd5) && (f.mm[3:0] <= 4'd9) &&
         (f.hh[5:4] <= 2'd2) && (f.hh[3:0] <= 4'd9);
    if (f.hh[5:4] == 2'd2 && f.hh[3:0] > 4'd3)
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Packed-BCD modulo counter (units nibble plus tens digit) that wraps from
// MAX to zero; used for the seconds, minutes and hours fields.
module bcd_mod_counter #(
  parameter int           W   = 7,
  parameter logic [W-1:0] MAX = 7'h59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic         carry
);

  localparam int TW = W - 4;

  logic [3:0]    units;
  logic [TW-1:0] tens;
  logic          at_max;
  logic [W-1:0]  nxt;

  assign units  = val[3:0];
  assign tens   = val[W-1:4];
  assign at_max = (val == MAX);
  assign carry  = at_max & inc;

  // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    nxt = '0;
    if (at_max)
      nxt = '0;
    else if (units == 4'd9)
      nxt = {tens + 1'b1, 4'd0};
    else
      nxt = {tens, units + 4'd1};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst)
      val <= '0;
    else if (ld)
      val <= ld_val;
    else if (inc)
      val <= nxt;
  end

endmodule

// File: rtl/timekeeper_hms.sv
// BCD hh:mm:ss time-of-day counter with a 1 Hz prescaler, validated load
// path and one-cycle tick / day-rollover pulses for the date stage.
module timekeeper_hms
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              time_ow,
  input  logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] time_out,
  output logic [HH_W-1:0]   hour_out,
  output logic              tick_1hz,
  output logic              day_wrap,
  output logic              load_err
);

  localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tc;
  logic          in_valid;
  logic          ld_ok;
  hms_t          ld_fields;

  logic [SS_W-1:0] ss_val;
  logic [MM_W-1:0] mm_val;
  logic [HH_W-1:0] hh_val;
  logic            ss_carry;
  logic            mm_carry;
  logic            hh_carry;

  // Loading wins over counting, so a terminal prescaler value seen while
  // time_ow is high never advances time.
  assign tc        = run_en & ~time_ow & (presc == PRESC_TC);
  assign in_valid  = bcd_time_valid(time_in);
  assign ld_ok     = time_ow & in_valid;
  assign ld_fields = hms_t'(time_in);

  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (time_ow)
      presc <= '0;
    else if (run_en)
      presc <= (presc == PRESC_TC) ? '0 : presc + 1'b1;
  end

  bcd_mod_counter #(.W(SS_W), .MAX(SEC_MAX)) u_ss (
    .clk    (clk),
    .rst    (rst),
    .inc    (tc),
    .ld     (ld_ok),
    .ld_val (ld_fields.ss),
    .val    (ss_val),
    .carry  (ss_carry)
  );

  bcd_mod_counter #(.W(MM_W), .MAX(MIN_MAX)) u_mm (
    .clk    (clk),
    .rst    (rst),
    .inc    (ss_carry),
    .ld     (ld_ok),
    .ld_val (ld_fields.mm),
    .val    (mm_val),
    .carry  (mm_carry)
  );

  bcd_mod_counter #(.W(HH_W), .MAX(HR_MAX)) u_hh (
    .clk    (clk),
    .rst    (rst),
    .inc    (mm_carry),
    .ld     (ld_ok),
    .ld_val (ld_fields.hh),
    .val    (hh_val),
    .carry  (hh_carry)
  );

  assign time_out = {hh_val, mm_val, ss_val};
  assign hour_out = hh_val;

  // Pulses are registered from the same edge that updates the counters,
  // so they line up with the new value on time_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick_1hz <= tc;
      day_wrap <= hh_carry;
      if (time_ow)
        load_err <= ~in_valid;
    end
  end

endmodule

// File: tb/tb_timekeeper_hms.sv
// Self-checking bench for timekeeper_hms: directed scenarios plus random
// stimulus, compared every cycle against a seconds-of-day reference model.
module tb_timekeeper_hms;

  localparam int HZ       = 4;
  localparam int DAY_SECS = 86400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0;
  logic        time_ow = 1'b0;
  logic [19:0] time_in = '0;
  logic [19:0] time_out;
  logic [5:0]  hour_out;
  logic        tick_1hz;
  logic        day_wrap;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  int   m_secs  = 0;
  int   m_presc = 0;
  logic m_tick  = 1'b0;
  logic m_wrap  = 1'b0;
  logic m_err   = 1'b0;

  timekeeper_hms #(.CLK_HZ(HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .time_ow  (time_ow),
    .time_in  (time_in),
    .time_out (time_out),
    .hour_out (hour_out),
    .tick_1hz (tick_1hz),
    .day_wrap (day_wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pack(input int h, input int m, input int s);
    logic [5:0] hb;
    logic [6:0] mb;
    logic [6:0] sb;
    hb = {2'(h / 10), 4'(h % 10)};
    mb = {3'(m / 10), 4'(m % 10)};
    sb = {3'(s / 10), 4'(s % 10)};
    return {hb, mb, sb};
  endfunction

  function automatic logic [19:0] secs_bcd(input int t);
    return pack(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  // Reference model: time is an integer second-of-day, not BCD digits.
  task automatic model_edge();
    int ht, hu, mt, mu, st, su;
    bit valid;
    if (rst) begin
      m_secs = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    end else if (time_ow) begin
      ht = int'(time_in[19:18]); hu = int'(time_in[17:14]);
      mt = int'(time_in[13:11]); mu = int'(time_in[10:7]);
      st = int'(time_in[6:4]);   su = int'(time_in[3:0]);
      valid = (hu <= 9) && (mu <= 9) && (su <= 9) &&
              (ht * 10 + hu < 24) && (mt * 10 + mu < 60) && (st * 10 + su < 60);
      if (valid) begin
        m_secs = (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60 + (st * 10 + su);
        m_err  = 0;
      end else begin
        m_err = 1;
      end
      m_presc = 0; m_tick = 0; m_wrap = 0;
    end else if (run_en) begin
      if (m_presc == HZ - 1) begin
        m_presc = 0;
        m_secs  = (m_secs + 1) % DAY_SECS;
        m_tick  = 1;
        m_wrap  = (m_secs == 0);
      end else begin
        m_presc++;
        m_tick = 0; m_wrap = 0;
      end
    end else begin
      m_tick = 0; m_wrap = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("time",  32'(time_out), 32'(secs_bcd(m_secs)));
    check("hour",  32'(hour_out), 32'(secs_bcd(m_secs) >> 14));
    check("tick",  32'(tick_1hz), 32'(m_tick));
    check("wrap",  32'(day_wrap), 32'(m_wrap));
    check("lderr", 32'(load_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input int h, input int m, input int s);
    time_ow = 1'b1;
    time_in = pack(h, m, s);
    cyc();
    time_ow = 1'b0;
  endtask

  initial begin
    int n;
    logic [19:0] pick;

    // 1: reset, then free-run from midnight
    rst = 1'b1;
    run(2);
    check("rst_time", 32'(time_out), 32'h0);
    check("rst_tick", 32'(tick_1hz), 32'h0);
    rst = 1'b0; run_en = 1'b1;
    run(4);
    check("s1_first_sec", 32'(time_out), 32'h00001);
    check("s1_first_tick", 32'(tick_1hz), 32'h1);
    n = 0;
    for (int i = 0; i < 36; i++) begin cyc(); if (tick_1hz) n++; end
    check("s1_ticks", 32'(n), 32'd9);
    check("s1_10s", 32'(time_out), 32'h00010);

    // 2: day rollover
    load(23, 59, 58);
    n = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (day_wrap) n++; end
    check("s2_wrap_count", 32'(n), 32'd1);
    check("s2_midnight", 32'(time_out), 32'h0);
    check("s2_hour00", 32'(hour_out), 32'h0);
    check("s2_wrap_now", 32'(day_wrap), 32'h1);
    cyc();
    check("s2_wrap_1cyc", 32'(day_wrap), 32'h0);

    // 3: BCD hour carries
    load(9, 59, 59);
    run(4);
    check("s3_hour10", 32'(hour_out), 32'h10);
    check("s3_time10", 32'(time_out), 32'h40000);
    load(19, 59, 59);
    run(4);
    check("s3_hour20", 32'(hour_out), 32'h20);

    // 4: invalid loads are rejected, a valid load clears the error
    load(24, 0, 0);
    check("s4_err_hr", 32'(load_err), 32'h1);
    check("s4_keep_hr", 32'(time_out), 32'(pack(20, 0, 0)));
    load(12, 60, 0);
    check("s4_err_min", 32'(load_err), 32'h1);
    check("s4_keep_min", 32'(time_out), 32'(pack(20, 0, 0)));
    load(12, 34, 56);
    check("s4_err_clr", 32'(load_err), 32'h0);
    check("s4_loaded", 32'(time_out), 32'(pack(12, 34, 56)));

    // 5: freeze mid-second
    run(2);
    run_en = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (tick_1hz) n++; end
    check("s5_frozen_ticks", 32'(n), 32'd0);
    run_en = 1'b1;
    cyc();
    check("s5_no_tick_yet", 32'(tick_1hz), 32'h0);
    cyc();
    check("s5_tick_resume", 32'(tick_1hz), 32'h1);
    check("s5_time", 32'(time_out), 32'(pack(12, 34, 57)));

    // 6: load in the tc cycle beats the rollover; reset mid-second
    load(23, 59, 59);
    run(3);
    load(8, 0, 0);
    check("s6_load_wins", 32'(time_out), 32'(pack(8, 0, 0)));
    check("s6_no_tick", 32'(tick_1hz), 32'h0);
    check("s6_no_wrap", 32'(day_wrap), 32'h0);
    run(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("s6_rst_time", 32'(time_out), 32'h0);
    run(3);
    check("s6_rst_presc", 32'(tick_1hz), 32'h0);
    cyc();
    check("s6_rst_tick", 32'(tick_1hz), 32'h1);

    // Random phase: mostly counting, occasional loads (valid and raw), rare reset
    for (int i = 0; i < 4000; i++) begin
      run_en  = ($urandom_range(0, 9) != 0);
      rst     = ($urandom_range(0, 499) == 0);
      time_ow = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0: pick = pack(23, 59, 50 + $urandom_range(0, 9));
        1: pick = pack($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        default: pick = 20'($urandom);
      endcase
      time_in = pick;
      cyc();
    end
    rst = 1'b0; time_ow = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
